// File: rtl/mu0_pkg.sv
// ----------------------------------------------------------------------------
// mu0_pkg
// Shared definitions for the MU0 core: default bus widths, the 4-bit opcode
// values and the encoding of the fetch/execute/halt state register.
// No ports (package).
// ----------------------------------------------------------------------------
package mu0_pkg;

   localparam int MU0_ADDR_W = 12;
   localparam int MU0_DATA_W = 16;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_STA = 4'h1;
   localparam logic [3:0] OP_ADD = 4'h2;
   localparam logic [3:0] OP_SUB = 4'h3;
   localparam logic [3:0] OP_JMP = 4'h4;
   localparam logic [3:0] OP_JGE = 4'h5;
   localparam logic [3:0] OP_JNE = 4'h6;
   localparam logic [3:0] OP_STP = 4'h7;

   localparam logic [1:0] ST_FETCH   = 2'b00;
   localparam logic [1:0] ST_EXECUTE = 2'b01;
   localparam logic [1:0] ST_HALT    = 2'b10;

endpackage

// File: rtl/mu0_alu.sv
// ----------------------------------------------------------------------------
// mu0_alu
// Combinational accumulator update for the MU0 core.
// Ports:
//   acc       in   current accumulator value
//   read_data in   operand read from memory
//   opcode    in   instruction opcode (IR top nibble)
//   next_acc  out  accumulator value after this instruction
//   n_flag    out  sign of the current accumulator (used by JGE)
//   z_flag    out  current accumulator is zero (used by JNE)
// ----------------------------------------------------------------------------
module mu0_alu
   import mu0_pkg::*;
#(
   parameter int DATA_W = MU0_DATA_W
) (
   input  logic [DATA_W-1:0] acc,
   input  logic [DATA_W-1:0] read_data,
   input  logic [3:0]        opcode,
   output logic [DATA_W-1:0] next_acc,
   output logic              n_flag,
   output logic              z_flag
);

   // Only loads and the two arithmetic ops change the accumulator; every
   // other opcode passes it through. Sums and differences wrap silently.
   always_comb begin
      next_acc = acc;
      case (opcode)
         OP_LDA:  next_acc = read_data;
         OP_ADD:  next_acc = acc + read_data;
         OP_SUB:  next_acc = acc - read_data;
         default: next_acc = acc;
      endcase
   end

   // Flags look at the accumulator as it was at the start of EXECUTE.
   assign n_flag = acc[DATA_W-1];
   assign z_flag = (acc == '0);

endmodule

// File: rtl/mu0_control_datapath.sv
// ----------------------------------------------------------------------------
// mu0_control_datapath
// MU0 processor core: fetch/execute/halt state machine with PC, IR and ACC.
// The external memory reads and writes on the falling edge; this core
// updates on the rising edge, so each access fits inside one Clk cycle.
// Ports:
//   Clk        in   system clock, registers update on posedge
//   Reset      in   asynchronous active-high reset
//   address    out  memory address (PC in FETCH/HALT, operand in EXECUTE)
//   write_data out  store data, always the accumulator
//   read_data  in   memory read data
//   WEn        out  memory write enable, high only while executing STA
//   Halted     out  high once STP has executed
//   pc_out     out  current PC
//   acc_out    out  current accumulator
// ----------------------------------------------------------------------------
module mu0_control_datapath
   import mu0_pkg::*;
#(
   parameter int                ADDR_W   = MU0_ADDR_W,
   parameter int                DATA_W   = MU0_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              Clk,
   input  logic              Reset,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] write_data,
   input  logic [DATA_W-1:0] read_data,
   output logic              WEn,
   output logic              Halted,
   output logic [ADDR_W-1:0] pc_out,
   output logic [DATA_W-1:0] acc_out
);

   logic [1:0]        state;
   logic [1:0]        next_state;
   logic [ADDR_W-1:0] pc;
   logic [DATA_W-1:0] ir;
   logic [DATA_W-1:0] acc;
   logic [3:0]        opcode;
   logic [ADDR_W-1:0] operand;
   logic [DATA_W-1:0] alu_next;
   logic              n_flag;
   logic              z_flag;

   assign opcode  = ir[DATA_W-1:DATA_W-4];
   assign operand = ir[ADDR_W-1:0];

   mu0_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .acc       (acc),
      .read_data (read_data),
      .opcode    (opcode),
      .next_acc  (alu_next),
      .n_flag    (n_flag),
      .z_flag    (z_flag)
   );

   // Fetch and execute alternate; STP parks the core in HALT until reset.
   // The unused encoding falls back to FETCH.
   always_comb begin
      next_state = ST_FETCH;
      case (state)
         ST_FETCH:   next_state = ST_EXECUTE;
         ST_EXECUTE: next_state = (opcode == OP_STP) ? ST_HALT : ST_FETCH;
         ST_HALT:    next_state = ST_HALT;
         default:    next_state = ST_FETCH;
      endcase
   end

   // Architectural registers. The PC is incremented during FETCH so that it
   // already points past the current instruction when EXECUTE decides on a
   // jump; an untaken or non-jump instruction simply leaves it there.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= ST_FETCH;
         pc    <= RESET_PC;
         ir    <= '0;
         acc   <= '0;
      end else begin
         state <= next_state;
         case (state)
            ST_FETCH: begin
               ir <= read_data;
               pc <= pc + 1'b1;
            end
            ST_EXECUTE: begin
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB: acc <= alu_next;
                  OP_JMP:                 pc  <= operand;
                  OP_JGE:                 if (!n_flag) pc <= operand;
                  OP_JNE:                 if (!z_flag) pc <= operand;
                  default:                ;
               endcase
            end
            default: ;
         endcase
      end
   end

   // The operand address is only presented during EXECUTE; in every other
   // state (including reset) the memory sees the PC.
   always_comb begin
      address = pc;
      if (state == ST_EXECUTE) begin
         address = operand;
      end
   end

   // The write enable is decoded purely from registers, so it is stable
   // across the falling edge where the memory performs the write.
   assign WEn        = (state == ST_EXECUTE) && (opcode == OP_STA);
   assign Halted     = (state == ST_HALT);
   assign write_data = acc;
   assign pc_out     = pc;
   assign acc_out    = acc;

endmodule
